// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// timeout default and a saturating counter helper.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fc_state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int TMO_W       = 8;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dffar.sv
// Flop with asynchronous active-high reset to zero.
module dffar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/dffare.sv
// Flop with load enable and asynchronous active-high reset to zero.
module dffare #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch controller: one outstanding memory fetch, IF/ID register,
// stall holding buffer, redirect squash, timeout flag and wait-cycle counter.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_start,
  output logic        pc_en,
  output logic [31:0] instr_if,
  output logic        instr_valid,
  output logic        imem_err,
  output logic [15:0] stall_cnt
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

  logic [1:0]       state_r;
  fc_state_e        state_q, state_d;
  logic             first_q, first_d;
  logic             ack_eff, waiting;
  logic             instr_en, buf_en;
  logic [31:0]      instr_d, buf_q;
  logic             valid_d, err_d;
  logic [15:0]      scnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign state_q = fc_state_e'(state_r);
  // An ack coinciding with the start pulse is a protocol violation and ignored.
  assign ack_eff = imem_ack & ~first_q;

  dffar  #(.W(2))     u_state (.clk, .rst, .d_i(state_d), .q_o(state_r));
  dffar  #(.W(1))     u_first (.clk, .rst, .d_i(first_d), .q_o(first_q));
  dffare #(.W(32))    u_instr (.clk, .rst, .en_i(instr_en), .d_i(instr_d), .q_o(instr_if));
  dffare #(.W(32))    u_buf   (.clk, .rst, .en_i(buf_en), .d_i(imem_rdata), .q_o(buf_q));
  dffar  #(.W(1))     u_valid (.clk, .rst, .d_i(valid_d), .q_o(instr_valid));
  dffar  #(.W(1))     u_err   (.clk, .rst, .d_i(err_d), .q_o(imem_err));
  dffar  #(.W(16))    u_scnt  (.clk, .rst, .d_i(scnt_d), .q_o(stall_cnt));
  dffar  #(.W(TMO_W)) u_tmo   (.clk, .rst, .d_i(tmo_d), .q_o(tmo_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (redirect)     state_d = ack_eff ? WAIT : DROP;
        else if (ack_eff) state_d = stall_id ? HOLD : WAIT;
      end
      HOLD: if (redirect || !stall_id) state_d = WAIT;
      DROP: if (ack_eff) state_d = WAIT;
      default: state_d = IDLE;
    endcase
    // A WAIT visit is new unless we simply keep waiting on the same fetch.
    first_d = (state_d == WAIT) && !(state_q == WAIT && !ack_eff);
  end

  always_comb begin
    imem_start = first_q;
    pc_en      = 1'b0;
    instr_en   = 1'b0;
    instr_d    = imem_rdata;
    buf_en     = 1'b0;
    valid_d    = instr_valid;
    case (state_q)
      WAIT: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
        end else if (ack_eff && !stall_id) begin
          pc_en    = 1'b1;
          instr_en = 1'b1;
          valid_d  = 1'b1;
        end else if (ack_eff) begin
          buf_en = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
        end else if (!stall_id) begin
          pc_en    = 1'b1;
          instr_en = 1'b1;
          instr_d  = buf_q;
          valid_d  = 1'b1;
        end
      end
      DROP: begin
        if (redirect) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    waiting = (state_q == WAIT || state_q == DROP) && !ack_eff;
    scnt_d  = waiting ? sat_inc16(stall_cnt) : stall_cnt;
    // The start cycle itself is the first waiting cycle of the new fetch,
    // so TIMEOUT waiting cycles bring the counter exactly to TIMEOUT.
    if (first_q)                         tmo_d = TMO_W'(1);
    else if (waiting && tmo_q != '1)     tmo_d = tmo_q + TMO_W'(1);
    else                                 tmo_d = tmo_q;
    err_d = imem_err | (waiting && tmo_d == TMO_LIM);
  end

endmodule
